// File: rtl/seq_detect_sched.sv
// Round-robin scheduler feeding one shared Moore pattern detector.
// Each granted channel streams one frame; a done pulse reports the match count.
module seq_detect_sched #(
  parameter int N_CH    = 4,
  parameter int MAX_LEN = 8,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [FRAME_W-1:0] cfg_frame_len,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH-1:0]    din,
  input  logic [N_CH-1:0]    din_valid,
  output logic [N_CH-1:0]    gnt,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic [2:0]         done_ch,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [N_CH-1:0] ONE_CH = {{(N_CH-1){1'b0}}, 1'b1};

  state_t             state_r, state_nx_s;
  logic [MAX_LEN-1:0] pat_r, mask_s, hist_nx_s;
  logic [3:0]         len_r, len_clamp_s, hist_cnt_r, hist_cnt_inc_s;
  logic               ovl_r;
  logic [FRAME_W-1:0] flen_r, bit_cnt_r, bit_cnt_inc_s;
  logic [CNT_W-1:0]   mcnt_r, mcnt_nx_s, match_cnt_r;
  // The oldest history bit drops out as the new one enters, so MAX_LEN-1 stored bits suffice.
  logic [MAX_LEN-2:0] hist_r;
  logic [N_CH-1:0]    gnt_r;
  logic [2:0]         g_r, rr_ptr_r, done_ch_r, pick_s, pick_hi_s, pick_lo_s;
  logic               hi_vld_s, pick_vld_s;
  logic               y_r, busy_r, done_r, abort_r;
  logic               accept_s, bit_s, drop_s, match_s, last_s;

  function automatic logic [2:0] next_ch(input logic [2:0] ch);
    if (ch == 3'(N_CH - 1)) next_ch = 3'd0;
    else next_ch = ch + 3'd1;
  endfunction

  assign len_clamp_s    = (cfg_len == 4'd0) ? 4'd1 :
                          (cfg_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : cfg_len;
  assign accept_s       = (state_r == RUN) && (flen_r != {FRAME_W{1'b0}}) && (|(gnt_r & din_valid));
  assign bit_s          = |(gnt_r & din);
  assign drop_s         = ~|(gnt_r & req);
  assign hist_nx_s      = {hist_r, bit_s};
  assign hist_cnt_inc_s = (hist_cnt_r == 4'(MAX_LEN)) ? hist_cnt_r : hist_cnt_r + 4'd1;
  assign bit_cnt_inc_s  = bit_cnt_r + {{(FRAME_W-1){1'b0}}, 1'b1};
  assign match_s        = accept_s && (hist_cnt_inc_s >= len_r) && ((hist_nx_s & mask_s) == (pat_r & mask_s));
  assign last_s         = accept_s && (bit_cnt_inc_s == flen_r);
  assign mcnt_nx_s      = (match_s && (mcnt_r != {CNT_W{1'b1}})) ? mcnt_r + {{(CNT_W-1){1'b0}}, 1'b1} : mcnt_r;

  // Pattern compare mask and round-robin pick (lowest requester at or after rr_ptr, else lowest overall).
  always_comb begin
    pick_hi_s = 3'd0;
    pick_lo_s = 3'd0;
    hi_vld_s  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len_r));
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      pick_lo_s = req[c] ? 3'(c) : pick_lo_s;
      pick_hi_s = (req[c] && (c >= int'(rr_ptr_r))) ? 3'(c) : pick_hi_s;
      hi_vld_s  = (req[c] && (c >= int'(rr_ptr_r))) ? 1'b1 : hi_vld_s;
    end
    pick_s     = hi_vld_s ? pick_hi_s : pick_lo_s;
    pick_vld_s = |req;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = pick_vld_s ? RUN : IDLE;
      RUN:     state_nx_s = (last_s || drop_s || (flen_r == {FRAME_W{1'b0}})) ? DONE : RUN;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Config, history, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r       <= {{(MAX_LEN-3){1'b0}}, 3'b101};
      len_r       <= 4'd3;
      ovl_r       <= 1'b1;
      flen_r      <= FRAME_W'(8);
      hist_r      <= {(MAX_LEN-1){1'b0}};
      hist_cnt_r  <= 4'd0;
      bit_cnt_r   <= {FRAME_W{1'b0}};
      mcnt_r      <= {CNT_W{1'b0}};
      match_cnt_r <= {CNT_W{1'b0}};
      gnt_r       <= {N_CH{1'b0}};
      g_r         <= 3'd0;
      rr_ptr_r    <= 3'd0;
      done_ch_r   <= 3'd0;
      y_r         <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      y_r     <= match_s;
      busy_r  <= (state_nx_s != IDLE);
      done_r  <= (state_nx_s == DONE);
      abort_r <= (state_r == RUN) && drop_s;
      case (state_r)
        IDLE: begin
          if (cfg_we) begin
            pat_r  <= cfg_pattern;
            len_r  <= len_clamp_s;
            ovl_r  <= cfg_overlap;
            flen_r <= cfg_frame_len;
          end
          if (pick_vld_s) begin
            g_r        <= pick_s;
            gnt_r      <= ONE_CH << pick_s;
            hist_r     <= {(MAX_LEN-1){1'b0}};
            hist_cnt_r <= 4'd0;
            bit_cnt_r  <= {FRAME_W{1'b0}};
            mcnt_r     <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          if (accept_s) begin
            hist_r     <= hist_nx_s[MAX_LEN-2:0];
            hist_cnt_r <= (match_s && !ovl_r) ? 4'd0 : hist_cnt_inc_s;
            bit_cnt_r  <= bit_cnt_inc_s;
            mcnt_r     <= mcnt_nx_s;
          end
          if (state_nx_s == DONE) begin
            gnt_r       <= {N_CH{1'b0}};
            done_ch_r   <= g_r;
            match_cnt_r <= mcnt_nx_s;
            rr_ptr_r    <= next_ch(g_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign y         = y_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign abort     = abort_r;
  assign done_ch   = done_ch_r;
  assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: the driver queues expected frame results,
// the monitor pops and compares them on each done pulse.
module tb_seq_detect_sched;
  localparam int N_CH = 4, MAX_LEN = 8, FRAME_W = 8, CNT_W = 8;

  logic               clk, rst, cfg_we, cfg_overlap;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic [FRAME_W-1:0] cfg_frame_len;
  logic [N_CH-1:0]    req, din, din_valid, gnt;
  logic               y, busy, done, abort;
  logic [2:0]         done_ch;
  logic [CNT_W-1:0]   match_cnt;

  typedef struct {
    logic [2:0]       ch;
    logic [CNT_W-1:0] cnt;
    logic             abort;
    logic [31:0]      mask;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  seq_detect_sched #(.N_CH(N_CH), .MAX_LEN(MAX_LEN), .FRAME_W(FRAME_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_frame_len(cfg_frame_len), .req(req), .din(din),
    .din_valid(din_valid), .gnt(gnt), .y(y), .busy(busy), .done(done), .abort(abort),
    .done_ch(done_ch), .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] fl);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_frame_len = fl;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // One frame on one channel; bits[0] is sent first, stall[i] inserts an idle cycle before bit i.
  task automatic send_frame(input int ch, input logic [31:0] bits, input int n, input logic [31:0] stall,
                            input logic drop, input int cnt, input logic [31:0] mask);
    exp_t e;
    logic [N_CH-1:0] m;
    int w;
    m = 4'b0001 << ch;
    e.ch = 3'(ch); e.cnt = CNT_W'(cnt); e.abort = drop; e.mask = mask;
    exp_q.push_back(e);
    req = req | m;
    w = 0;
    while (((gnt & m) == 4'd0) && (w < 20)) begin
      tick();
      w++;
    end
    chk("gnt_latency", w, 1);
    for (int i = 0; i < n; i++) begin
      if (stall[i]) begin
        din_valid = din_valid & ~m;
        tick();
      end
      din       = bits[i] ? (din | m) : (din & ~m);
      din_valid = din_valid | m;
      if (drop && (i == n - 1)) req = req & ~m;
      tick();
    end
    din_valid = din_valid & ~m;
    req       = req & ~m;
    tick();
  endtask

  // All channels request continuously; each granted frame is fed seq LSB first.
  task automatic rr_run(input int start, input int nfr, input logic [7:0] seq, input int cnt, input logic [31:0] mask);
    exp_t e;
    int k, seen, w;
    for (int f = 0; f < nfr; f++) begin
      e.ch = 3'((start + f) % N_CH); e.cnt = CNT_W'(cnt); e.abort = 1'b0; e.mask = mask;
      exp_q.push_back(e);
    end
    req = 4'hF; din_valid = 4'hF; din = 4'h0;
    k = 0; seen = 0; w = 0;
    while ((seen < nfr) && (w < 400)) begin
      tick();
      w++;
      if (done) seen++;
      if (gnt != 4'd0) begin
        din = {N_CH{seq[k % 8]}};
        k++;
      end else begin
        k = 0;
      end
    end
    req = 4'h0; din_valid = 4'h0;
    chk("rr_frames", seen, nfr);
    tick();
  endtask

  // Monitor: records y pulses against the accepted-bit index and checks each done.
  initial begin : mon
    int nb;
    logic [31:0] ym;
    exp_t e;
    nb = 0; ym = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nb = 0; ym = 32'd0;
      end else begin
        chk("gnt_onehot", ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (y) begin
          if (nb == 0) chk("y_stray", {31'd0, y}, 32'd0);
          else begin
            chk("y_double", {31'd0, ym[nb-1]}, 32'd0);
            ym[nb-1] = 1'b1;
          end
        end
        if (done) begin
          if (exp_q.size() == 0) chk("done_unexpected", {31'd0, done}, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("done_ch", done_ch, e.ch);
            chk("match_cnt", match_cnt, e.cnt);
            chk("abort", abort, e.abort);
            chk("y_pulses", ym, e.mask);
          end
          nb = 0; ym = 32'd0;
        end
        if (|(gnt & din_valid)) nb++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : drv
    int w;
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    cfg_frame_len = 8'd0; req = 4'h0; din = 4'h0; din_valid = 4'h0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_gnt", gnt, 0); chk("rst_y", y, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_abort", abort, 0); chk("rst_done_ch", done_ch, 0); chk("rst_match_cnt", match_cnt, 0);

    // Reset config, overlapping 101 with stalls before bits 4 and 7.
    send_frame(0, 32'hB5, 8, 32'h48, 1'b0, 3, 32'h94);
    // Non-overlapping.
    cfg(8'h05, 4'd3, 1'b0, 8'd8);
    send_frame(0, 32'hB5, 8, 32'h0, 1'b0, 2, 32'h84);
    // ch2 drops req with its third bit.
    cfg(8'h05, 4'd3, 1'b1, 8'd8);
    send_frame(2, 32'h5, 3, 32'h0, 1'b1, 1, 32'h4);
    // All request, two-bit frames; rotation resumes at ch3 after the ch2 abort.
    cfg(8'h05, 4'd3, 1'b1, 8'd2);
    rr_run(3, 5, 8'h00, 0, 32'h0);
    // Config write during RUN must be ignored.
    cfg(8'h05, 4'd3, 1'b1, 8'd8);
    fork
      send_frame(0, 32'hB5, 8, 32'h0, 1'b0, 3, 32'h94);
      begin
        w = 0;
        while (!gnt[0] && (w < 20)) begin tick(); w++; end
        tick(); tick();
        cfg_pattern = 8'h0F; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_frame_len = 8'd6;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
      end
    join
    // Same write in IDLE, six 1s.
    cfg(8'h0F, 4'd4, 1'b1, 8'd6);
    send_frame(1, 32'h3F, 6, 32'h0, 1'b0, 3, 32'h38);

    // Asynchronous reset mid-frame, during a y pulse.
    req = 4'b0010;
    w = 0;
    while (!gnt[1] && (w < 20)) begin tick(); w++; end
    chk("rst_test_gnt", gnt, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      din = 4'b0010; din_valid = 4'b0010;
      tick();
    end
    chk("y_before_rst", y, 1);
    chk("busy_before_rst", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_gnt", gnt, 0); chk("async_y", y, 0); chk("async_busy", busy, 0);
    chk("async_done", done, 0); chk("async_done_ch", done_ch, 0); chk("async_match_cnt", match_cnt, 0);
    req = 4'h0; din = 4'h0; din_valid = 4'h0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Default config and rr_ptr 0 restored: 8-bit frames of 101 data, order 0,1,2,3,0.
    rr_run(0, 5, 8'hB5, 3, 32'h94);

    tick(); tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Scheduler and controller for a shared Moore sequence-detection datapath. Up to N_CH serial bit-stream requesters compete for the detector. A round-robin arbiter grants one channel a frame of cfg_frame_len bits. The detector matches a programmable pattern (length 1..MAX_LEN, overlapping or non-overlapping) and reports a per-frame match count with a done pulse. It sits between the serial front-end channels and the status/interrupt logic.

## Interface
- N_CH, 4: number of requesting channels (2..8)
- MAX_LEN, 8: maximum pattern length in bits
- FRAME_W, 8: width of frame length and bit counter
- CNT_W, 8: width of match counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  load config; honoured only in IDLE
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is first bit received, bit 0 is last
- cfg_len  in  4  pattern length; 0 treated as 1, >MAX_LEN clamped to MAX_LEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after each match
- cfg_frame_len  in  FRAME_W  bits per frame
- req  in  N_CH  per-channel frame request, level
- din  in  N_CH  per-channel serial bit
- din_valid  in  N_CH  per-channel bit valid
- gnt  out  N_CH  one-hot grant, registered; doubles as din ready
- y  out  1  Moore detect output, registered
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle frame-complete pulse
- abort  out  1  qualifies done: frame ended by req drop
- done_ch  out  3  channel index of completed frame, valid with done, held after
- match_cnt  out  CNT_W  matches in last frame; held until the next done

## Operation
- States:
  - IDLE: cfg_we loads the config registers. If any req is set, pick the first requesting channel at or after rr_ptr, set its gnt bit, clear the history/bit/match counters, and go to RUN.
  - RUN: a bit is accepted when gnt[g] & din_valid[g]; din of other channels is ignored.
  - DONE: one cycle, then IDLE.
- RUN exits to DONE:
  - when bit_cnt reaches cfg_frame_len after an accepted bit;
  - immediately if cfg_frame_len = 0 (match_cnt 0);
  - if req[g] drops (abort = 1); a bit accepted in that same cycle still counts.
- DONE: gnt = 0, done = 1, done_ch = g, match_cnt updated, rr_ptr = g+1 modulo N_CH.
- cfg_we outside IDLE is ignored; config registers do not change mid-frame.
- History is a MAX_LEN shift register with the new bit entering bit 0. hist_cnt counts valid bits and saturates at MAX_LEN.
- Match condition: an accepted bit makes hist_cnt ≥ cfg_len and hist[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
  - On match: match_cnt_int increments, saturating at all-ones.
  - If cfg_overlap = 0, hist_cnt is cleared, so the next match needs cfg_len fresh bits.
- y is registered from the match condition. It is high exactly one cycle after each matching bit's accepting edge, and 0 otherwise, including in IDLE.
- Reset values:
  - state IDLE, gnt 0, y 0, busy 0, done 0, abort 0, done_ch 0, match_cnt 0, rr_ptr 0;
  - config: pattern 'b101, len 3, overlap 1, frame_len 8.
- Reset mid-frame takes effect immediately, with no clock edge. The frame is discarded and no done is issued.

## Timing
- req seen in IDLE at edge k gives gnt high after edge k (cycle k+1); first bit can be accepted at edge k+1.
- Matching bit accepted at edge m gives y = 1 during cycle m+1 only.
- Last bit accepted at edge m gives state DONE, done = 1, match_cnt valid during cycle m+1. y for that bit coincides with done.
- After done: one IDLE cycle. Next gnt is earliest two cycles after done.
- Throughput: one bit per cycle while din_valid is held high.
- Stalls (din_valid low) freeze all counters and history; y is 0 during stall cycles.

## Test plan
- Reset config, ch0 only, bits 1,0,1,0,1,1,0,1 back-to-back -> y pulses after bits 3, 5, 8; done with match_cnt 3, done_ch 0, abort 0.
- Same stimulus with cfg_overlap 0 -> y after bits 3 and 8; match_cnt 2.
- req = 4'b1111 held, cfg_frame_len 2 -> grant order ch0, ch1, ch2, ch3, ch0; done_ch 0, 1, 2, 3, 0; exactly one gnt bit high at any time.
- ch2 granted, drops req after 3 bits 1,0,1 -> done with abort 1, match_cnt 1, done_ch 2; next grant is ch3 if requesting.
- cfg_we with pattern 'b1111, len 4 pulsed during RUN -> ignored (frame uses 'b101). Same write in IDLE, then frame of six 1s, frame_len 6 -> match_cnt 3.
- rst asserted mid-frame, between edges -> gnt, y, busy, done go to 0 asynchronously, no done pulse. After release, config is back to 'b101 / len 3 and rr_ptr is 0.
